// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode definitions.
//   - opcode / funct encodings for the supported subset
//   - alu_op_e: ALU operation carried down the pipe
//   - REG_LINK: link register written by JAL
//   - idex_t: ID/EX pipeline register contents
//   - sext16: sign extension of a 16-bit immediate
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [4:0] REG_LINK = 5'd31;

   // ALU_ADD must stay encoded as 0: a zeroed ID/EX register is a NOP bubble.
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  dst;
      alu_op_e     alu_op;
      logic        alu_src;
      logic        mem_rd;
      logic        mem_wr;
      logic        link;
   } idex_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: IF/ID inputs, write-back port, fetch redirect and ID/EX outputs
// of the decode stage.
//   master: fetch/write-back/execute side (drives IF/ID + write-back)
//   slave : the decode stage
interface decode_if;
   import mips_pkg::*;

   logic [31:0] pc_if_id;
   logic [31:0] ir_if_id;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   logic        jump;
   logic [31:0] addr;

   logic [31:0] pc_id_ex;
   logic [31:0] rs_id_ex;
   logic [31:0] rt_id_ex;
   logic [31:0] imm_id_ex;
   logic [4:0]  dst_id_ex;
   alu_op_e     alu_op_id_ex;
   logic        alu_src_id_ex;
   logic        mem_rd_id_ex;
   logic        mem_wr_id_ex;
   logic        link_id_ex;

   modport master (
      output pc_if_id, ir_if_id, wb_en, wb_reg, wb_data,
      input  jump, addr, pc_id_ex, rs_id_ex, rt_id_ex, imm_id_ex, dst_id_ex,
             alu_op_id_ex, alu_src_id_ex, mem_rd_id_ex, mem_wr_id_ex, link_id_ex
   );

   modport slave (
      input  pc_if_id, ir_if_id, wb_en, wb_reg, wb_data,
      output jump, addr, pc_id_ex, rs_id_ex, rt_id_ex, imm_id_ex, dst_id_ex,
             alu_op_id_ex, alu_src_id_ex, mem_rd_id_ex, mem_wr_id_ex, link_id_ex
   );
endinterface

// File: rtl/regfile.sv
// regfile: REG_COUNT x WORD_SIZE register file, 2 async read ports, 1 write port.
//   clk, rst       : clock, async active-high reset (clears every register)
//   we_i/wa_i/wd_i : write port, sampled on rising clk; writes to r0 dropped
//   ra0_i/ra1_i    : read indices
//   rd0_o/rd1_o    : read data; r0 reads zero, a same-cycle write is forwarded
module regfile #(
   parameter int WORD_SIZE = 32,
   parameter int REG_COUNT = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_i,
   input  logic [4:0]           wa_i,
   input  logic [WORD_SIZE-1:0] wd_i,
   input  logic [4:0]           ra0_i,
   input  logic [4:0]           ra1_i,
   output logic [WORD_SIZE-1:0] rd0_o,
   output logic [WORD_SIZE-1:0] rd1_o
);

   logic [WORD_SIZE-1:0] regs_q [REG_COUNT];

   // r0 is cleared by reset and never written, so it stays zero in storage too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else if (we_i && wa_i != 5'd0) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   // Write-through: decode sees the value being written back this cycle.
   assign rd0_o = (ra0_i == 5'd0)                ? '0   :
                  (we_i && wa_i == ra0_i)        ? wd_i : regs_q[ra0_i];
   assign rd1_o = (ra1_i == 5'd0)                ? '0   :
                  (we_i && wa_i == ra1_i)        ? wd_i : regs_q[ra1_i];

endmodule

// File: rtl/decode.sv
// decode: MIPS instruction decode stage.
//   clk, rst : clock, async active-high reset (ID/EX -> NOP bubble, regs -> 0)
//   bus      : decode_if.slave
//      in : pc_if_id (PC+1, word address), ir_if_id, wb_en/wb_reg/wb_data
//      out: jump/addr (combinational fetch redirect), *_id_ex (registered)
// Unsupported encodings decode as a NOP: control low, dst 0, imm 0.
// Shift amount travels in imm_id_ex with alu_src low; R-type ops never take
// an immediate as operand B, the ALU picks the shift amount by alu_op.
module decode
   import mips_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int REG_COUNT = 32
) (
   input  logic   clk,
   input  logic   rst,
   decode_if.slave bus
);

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh;
   logic [15:0] imm;
   logic [25:0] tgt;
   logic [31:0] pc;

   assign op  = bus.ir_if_id[31:26];
   assign rs  = bus.ir_if_id[25:21];
   assign rt  = bus.ir_if_id[20:16];
   assign rd  = bus.ir_if_id[15:11];
   assign sh  = bus.ir_if_id[10:6];
   assign fn  = bus.ir_if_id[5:0];
   assign imm = bus.ir_if_id[15:0];
   assign tgt = bus.ir_if_id[25:0];
   assign pc  = bus.pc_if_id;

   logic [WORD_SIZE-1:0] rs_val, rt_val;

   regfile #(.WORD_SIZE(WORD_SIZE), .REG_COUNT(REG_COUNT)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we_i  (bus.wb_en),
      .wa_i  (bus.wb_reg),
      .wd_i  (bus.wb_data),
      .ra0_i (rs),
      .ra1_i (rt),
      .rd0_o (rs_val),
      .rd1_o (rt_val)
   );

   idex_t       idex_d, idex_q;
   logic        jump;
   logic [31:0] addr;

   always_comb begin
      idex_d        = '0;
      idex_d.alu_op = ALU_ADD;
      idex_d.pc     = pc;
      idex_d.rs     = rs_val;
      idex_d.rt     = rt_val;
      jump          = 1'b0;
      addr          = pc;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_SLL, FN_SRL, FN_SRA: begin
                  idex_d.alu_op = (fn == FN_SLL) ? ALU_SLL :
                                  (fn == FN_SRL) ? ALU_SRL : ALU_SRA;
                  idex_d.imm    = {27'd0, sh};
                  idex_d.dst    = rd;
               end
               FN_JR: begin
                  jump = 1'b1;
                  addr = rs_val;
               end
               FN_JALR: begin
                  jump        = 1'b1;
                  addr        = rs_val;
                  idex_d.dst  = rd;
                  idex_d.link = 1'b1;
               end
               FN_ADDU: begin idex_d.alu_op = ALU_ADD; idex_d.dst = rd; end
               FN_SUBU: begin idex_d.alu_op = ALU_SUB; idex_d.dst = rd; end
               FN_AND:  begin idex_d.alu_op = ALU_AND; idex_d.dst = rd; end
               FN_OR:   begin idex_d.alu_op = ALU_OR;  idex_d.dst = rd; end
               FN_XOR:  begin idex_d.alu_op = ALU_XOR; idex_d.dst = rd; end
               FN_NOR:  begin idex_d.alu_op = ALU_NOR; idex_d.dst = rd; end
               FN_SLT:  begin idex_d.alu_op = ALU_SLT; idex_d.dst = rd; end
               default: ;
            endcase
         end
         OP_J: begin
            jump = 1'b1;
            addr = {pc[31:26], tgt};
         end
         OP_JAL: begin
            jump        = 1'b1;
            addr        = {pc[31:26], tgt};
            idex_d.dst  = REG_LINK;
            idex_d.link = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            idex_d.imm = sext16(imm);
            jump       = (op == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
            addr       = pc + sext16(imm);
         end
         OP_ADDIU, OP_SLTI, OP_LW: begin
            idex_d.alu_op  = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            idex_d.alu_src = 1'b1;
            idex_d.imm     = sext16(imm);
            idex_d.dst     = rt;
            idex_d.mem_rd  = (op == OP_LW);
         end
         OP_SW: begin
            idex_d.alu_src = 1'b1;
            idex_d.imm     = sext16(imm);
            idex_d.mem_wr  = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            idex_d.alu_op  = (op == OP_ANDI) ? ALU_AND :
                             (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            idex_d.alu_src = 1'b1;
            idex_d.imm     = {16'd0, imm};
            idex_d.dst     = rt;
         end
         OP_LUI: begin
            idex_d.alu_op  = ALU_LUI;
            idex_d.alu_src = 1'b1;
            idex_d.imm     = {imm, 16'd0};
            idex_d.dst     = rt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign bus.jump          = jump;
   assign bus.addr          = addr;
   assign bus.pc_id_ex      = idex_q.pc;
   assign bus.rs_id_ex      = idex_q.rs;
   assign bus.rt_id_ex      = idex_q.rt;
   assign bus.imm_id_ex     = idex_q.imm;
   assign bus.dst_id_ex     = idex_q.dst;
   assign bus.alu_op_id_ex  = idex_q.alu_op;
   assign bus.alu_src_id_ex = idex_q.alu_src;
   assign bus.mem_rd_id_ex  = idex_q.mem_rd;
   assign bus.mem_wr_id_ex  = idex_q.mem_wr;
   assign bus.link_id_ex    = idex_q.link;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed vectors for the decode stage, checked every cycle
// against a mnemonic-level model, plus literal expectations for key cases.
module tb_decode;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_if bus ();
   decode dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_NOP, M_SLL, M_SRL, M_SRA, M_JR, M_JALR, M_ADDU, M_SUBU, M_AND,
                 M_OR, M_XOR, M_NOR, M_SLT, M_J, M_JAL, M_BEQ, M_BNE, M_ADDIU,
                 M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW} mn_e;

   typedef struct packed {
      logic        jump;
      logic [31:0] addr, pc, rs, rt, imm;
      logic [4:0]  dst;
      logic [3:0]  alu;
      logic        src, mrd, mwr, link;
   } exp_t;

   logic [31:0] mregs [32];
   exp_t        exp_q;

   function automatic logic [31:0] rdreg(input logic [4:0] i, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
      if (i == 0) return 32'd0;
      if (we && wr == i) return wd;
      return mregs[i];
   endfunction

   function automatic exp_t model(input logic [31:0] ir, pc, input logic we,
                                  input logic [4:0] wr, input logic [31:0] wd);
      exp_t e;
      mn_e  m;
      logic [31:0] sx;
      m = M_NOP;
      case (ir[31:26])
         6'd0: case (ir[5:0])
            6'h00: m = M_SLL;  6'h02: m = M_SRL;  6'h03: m = M_SRA;
            6'h08: m = M_JR;   6'h09: m = M_JALR; 6'h21: m = M_ADDU;
            6'h23: m = M_SUBU; 6'h24: m = M_AND;  6'h25: m = M_OR;
            6'h26: m = M_XOR;  6'h27: m = M_NOR;  6'h2A: m = M_SLT;
            default: m = M_NOP;
         endcase
         6'h02: m = M_J;    6'h03: m = M_JAL;  6'h04: m = M_BEQ;  6'h05: m = M_BNE;
         6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI; 6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;
         6'h0E: m = M_XORI; 6'h0F: m = M_LUI;  6'h23: m = M_LW;   6'h2B: m = M_SW;
         default: m = M_NOP;
      endcase
      sx     = {{16{ir[15]}}, ir[15:0]};
      e      = '0;
      e.pc   = pc;
      e.rs   = rdreg(ir[25:21], we, wr, wd);
      e.rt   = rdreg(ir[20:16], we, wr, wd);
      e.addr = pc;
      if (m inside {M_ADDIU, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE}) e.imm = sx;
      if (m inside {M_ANDI, M_ORI, M_XORI}) e.imm = {16'd0, ir[15:0]};
      if (m == M_LUI) e.imm = {ir[15:0], 16'd0};
      if (m inside {M_SLL, M_SRL, M_SRA}) e.imm = {27'd0, ir[10:6]};
      if (m inside {M_SLL, M_SRL, M_SRA, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR,
                    M_NOR, M_SLT, M_JALR}) e.dst = ir[15:11];
      if (m inside {M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW}) e.dst = ir[20:16];
      if (m == M_JAL) e.dst = 5'd31;
      case (m)
         M_SUBU:          e.alu = ALU_SUB;
         M_AND, M_ANDI:   e.alu = ALU_AND;
         M_OR, M_ORI:     e.alu = ALU_OR;
         M_XOR, M_XORI:   e.alu = ALU_XOR;
         M_NOR:           e.alu = ALU_NOR;
         M_SLT, M_SLTI:   e.alu = ALU_SLT;
         M_SLL:           e.alu = ALU_SLL;
         M_SRL:           e.alu = ALU_SRL;
         M_SRA:           e.alu = ALU_SRA;
         M_LUI:           e.alu = ALU_LUI;
         default:         e.alu = ALU_ADD;
      endcase
      e.src  = m inside {M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW};
      e.mrd  = (m == M_LW);
      e.mwr  = (m == M_SW);
      e.link = m inside {M_JAL, M_JALR};
      case (m)
         M_BEQ:       begin e.jump = (e.rs == e.rt); e.addr = pc + sx; end
         M_BNE:       begin e.jump = (e.rs != e.rt); e.addr = pc + sx; end
         M_J, M_JAL:  begin e.jump = 1'b1; e.addr = {pc[31:26], ir[25:0]}; end
         M_JR, M_JALR: begin e.jump = 1'b1; e.addr = e.rs; end
         default: ;
      endcase
      return e;
   endfunction

   // model state: expected ID/EX contents and architectural registers
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= '0;
         for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      end else begin
         exp_q <= model(bus.ir_if_id, bus.pc_if_id, bus.wb_en, bus.wb_reg, bus.wb_data);
         if (bus.wb_en && bus.wb_reg != 5'd0) mregs[bus.wb_reg] <= bus.wb_data;
      end
   end

   // compare process: every cycle outside reset
   always @(negedge clk) begin : cmp
      exp_t c;
      if (!rst) begin
         c = model(bus.ir_if_id, bus.pc_if_id, bus.wb_en, bus.wb_reg, bus.wb_data);
         check("jump",    {31'd0, bus.jump}, {31'd0, c.jump});
         check("addr",    bus.addr, c.addr);
         check("pc_id_ex",  bus.pc_id_ex,  exp_q.pc);
         check("rs_id_ex",  bus.rs_id_ex,  exp_q.rs);
         check("rt_id_ex",  bus.rt_id_ex,  exp_q.rt);
         check("imm_id_ex", bus.imm_id_ex, exp_q.imm);
         check("dst_id_ex", {27'd0, bus.dst_id_ex}, {27'd0, exp_q.dst});
         check("alu_op",    {28'd0, bus.alu_op_id_ex}, {28'd0, exp_q.alu});
         check("ctrl",      {28'd0, bus.alu_src_id_ex, bus.mem_rd_id_ex, bus.mem_wr_id_ex, bus.link_id_ex},
                            {28'd0, exp_q.src, exp_q.mrd, exp_q.mwr, exp_q.link});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic [31:0] ir, pc, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
      @(posedge clk); #1;
      bus.ir_if_id = ir; bus.pc_if_id = pc;
      bus.wb_en = we; bus.wb_reg = wr; bus.wb_data = wd;
   endtask

   task automatic check_idex_zero(input string tag);
      check({tag, " pc"},  bus.pc_id_ex, 32'd0);
      check({tag, " rs"},  bus.rs_id_ex, 32'd0);
      check({tag, " imm"}, bus.imm_id_ex, 32'd0);
      check({tag, " dst"}, {27'd0, bus.dst_id_ex}, 32'd0);
      check({tag, " alu"}, {28'd0, bus.alu_op_id_ex}, 32'd0);
      check({tag, " ctrl"}, {28'd0, bus.alu_src_id_ex, bus.mem_rd_id_ex,
                             bus.mem_wr_id_ex, bus.link_id_ex}, 32'd0);
   endtask

   localparam logic [31:0] NOP = 32'h0000_0000;

   initial begin
      bus.ir_if_id = 32'h2402_FFFD; bus.pc_if_id = 32'h55;
      bus.wb_en = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0;
      repeat (2) @(posedge clk);
      #1 check_idex_zero("reset");
      @(negedge clk) rst = 1'b0;

      // preload registers
      step(NOP, 32'h10, 1'b1, 5'd1, 32'h0000_0011);
      step(NOP, 32'h11, 1'b1, 5'd2, 32'h0000_0022);
      step(NOP, 32'h12, 1'b1, 5'd3, 32'h8000_0000);
      step(NOP, 32'h13, 1'b1, 5'd5, 32'hA5A5_A5A5);
      step(NOP, 32'h14, 1'b1, 5'd6, 32'h0000_0007);

      // ADDIU r2,r0,-3
      step(32'h2402_FFFD, 32'h40, 1'b0, 5'd0, 32'd0);
      #2 check("addiu jump", {31'd0, bus.jump}, 32'd0);
      step(32'h0022_3821, 32'h41, 1'b0, 5'd0, 32'd0);   // ADDU r7,r1,r2
      check("addiu imm", bus.imm_id_ex, 32'hFFFF_FFFD);
      check("addiu dst", {27'd0, bus.dst_id_ex}, 32'd2);
      check("addiu src", {31'd0, bus.alu_src_id_ex}, 32'd1);

      // BEQ r4,r0,+8 with write-through of r4
      step(32'h1080_0008, 32'h100, 1'b1, 5'd4, 32'h1234);
      #2 check("beq bypass nt", {31'd0, bus.jump}, 32'd0);
      step(32'h1080_0008, 32'h100, 1'b1, 5'd4, 32'h0);
      #2 check("beq bypass t", {31'd0, bus.jump}, 32'd1);
      check("beq addr", bus.addr, 32'h108);

      // JAL
      step(32'h0C00_0100, 32'h0400_0010, 1'b0, 5'd0, 32'd0);
      #2 check("jal jump", {31'd0, bus.jump}, 32'd1);
      check("jal addr", bus.addr, 32'h0400_0100);
      // OR r1,r0,r0 while writing r0
      step(32'h0000_0825, 32'h0400_0011, 1'b1, 5'd0, 32'hFFFF_FFFF);
      check("jal dst", {27'd0, bus.dst_id_ex}, 32'd31);
      check("jal link", {31'd0, bus.link_id_ex}, 32'd1);
      step(32'h0000_0825, 32'h0400_0012, 1'b0, 5'd0, 32'd0);
      check("or r0 rs", bus.rs_id_ex, 32'd0);
      check("or r0 rt", bus.rt_id_ex, 32'd0);

      // undefined opcode 0x3F
      step(32'hFC22_1234, 32'h300, 1'b0, 5'd0, 32'd0);
      #2 check("undef jump", {31'd0, bus.jump}, 32'd0);
      step(32'h0022_3801, 32'h301, 1'b0, 5'd0, 32'd0);   // undefined funct
      check("undef dst", {27'd0, bus.dst_id_ex}, 32'd0);
      check("undef alu", {28'd0, bus.alu_op_id_ex}, 32'd0);
      check("undef ctrl", {28'd0, bus.alu_src_id_ex, bus.mem_rd_id_ex,
                           bus.mem_wr_id_ex, bus.link_id_ex}, 32'd0);

      // remaining instruction classes (model-checked, some pinned)
      step(32'h1422_FFFC, 32'h200, 1'b0, 5'd0, 32'd0);   // BNE r1,r2,-4 taken
      #2 check("bne addr", bus.addr, 32'h1FC);
      step(32'h1421_FFFC, 32'h200, 1'b0, 5'd0, 32'd0);   // BNE r1,r1 not taken
      step(32'h08AB_CDEF, 32'hF000_0000, 1'b0, 5'd0, 32'd0); // J
      #2 check("j addr", bus.addr, 32'hF0AB_CDEF);
      step(32'h0060_0008, 32'h500, 1'b0, 5'd0, 32'd0);   // JR r3
      #2 check("jr addr", bus.addr, 32'h8000_0000);
      step(32'h00A0_4809, 32'h501, 1'b0, 5'd0, 32'd0);   // JALR r9,r5
      step(32'h0006_4100, 32'h502, 1'b0, 5'd0, 32'd0);   // SLL r8,r6,4
      step(32'h0003_47C3, 32'h503, 1'b0, 5'd0, 32'd0);   // SRA r8,r3,31
      check("sll imm", bus.imm_id_ex, 32'd4);
      step(32'h0003_47C2, 32'h504, 1'b0, 5'd0, 32'd0);   // SRL r8,r3,31
      step(32'h3C0A_8001, 32'h505, 1'b0, 5'd0, 32'd0);   // LUI r10,0x8001
      step(32'h346B_8000, 32'h506, 1'b0, 5'd0, 32'd0);   // ORI r11,r3,0x8000
      check("lui imm", bus.imm_id_ex, 32'h8001_0000);
      step(32'h286C_FFFF, 32'h507, 1'b0, 5'd0, 32'd0);   // SLTI r12,r3,-1
      check("ori imm", bus.imm_id_ex, 32'h0000_8000);
      step(32'h306D_00FF, 32'h508, 1'b0, 5'd0, 32'd0);   // ANDI
      step(32'h386E_FFFF, 32'h509, 1'b0, 5'd0, 32'd0);   // XORI
      step(32'h0022_3823, 32'h50A, 1'b0, 5'd0, 32'd0);   // SUBU
      step(32'h0022_3824, 32'h50B, 1'b0, 5'd0, 32'd0);   // AND
      step(32'h0022_3826, 32'h50C, 1'b0, 5'd0, 32'd0);   // XOR
      step(32'h0022_3827, 32'h50D, 1'b0, 5'd0, 32'd0);   // NOR
      step(32'h0062_382A, 32'h50E, 1'b0, 5'd0, 32'd0);   // SLT
      step(32'hAC26_0008, 32'h50F, 1'b0, 5'd0, 32'd0);   // SW r6,8(r1)
      step(32'h8CA9_FFFC, 32'h510, 1'b0, 5'd0, 32'd0);   // LW r9,-4(r5)
      check("sw mem_wr", {31'd0, bus.mem_wr_id_ex}, 32'd1);
      step(32'h0022_3821, 32'h511, 1'b1, 5'd7, 32'h77);
      check("lw rs", bus.rs_id_ex, 32'hA5A5_A5A5);
      check("lw mem_rd", {31'd0, bus.mem_rd_id_ex}, 32'd1);

      // reset mid-cycle discards ID/EX and the register file
      @(posedge clk); #3 rst = 1'b1;
      #1 check_idex_zero("midrst");
      @(negedge clk) rst = 1'b0;
      step(32'h00A0_4021, 32'h600, 1'b0, 5'd0, 32'd0);   // ADDU r8,r5,r0
      step(NOP, 32'h601, 1'b0, 5'd0, 32'd0);
      check("r5 after reset", bus.rs_id_ex, 32'd0);
      step(NOP, 32'h602, 1'b0, 5'd0, 32'd0);
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
